// File: rtl/scariv_lsu_replay_sender.sv
// scariv_lsu_replay_sender
//   Transmit side of the LSU replay path. EX2 hazard reports are parked in a
//   small entry pool until their hazard clears, then the oldest cleared entry
//   is moved into a registered valid/ready output stage for the front-end
//   arbiter.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_haz_*                 EX2 hazard report (cmt/grp id, type, wake index, payload)
//   i_missu_resolve_oh      miss-unit entries resolved this cycle
//   i_missu_is_full         miss unit full (typ 1 waits for it to drop)
//   i_stq_resolve_oh        store-queue rs2 resolved this cycle
//   i_flush_all             kill everything
//   i_br_flush_*            kill everything strictly younger than the branch
//   o_full, o_almost_full   registered occupancy flags
//   o_req_*, i_req_ready    replay request towards the arbiter
//
// Configuration
//   LSU_REPLAY_PERF_CNT_EN  adds o_perf_replay_cnt (handshakes) and
//                           o_perf_full_cyc (cycles with o_full=1), both saturating.
module scariv_lsu_replay_sender #(
    parameter int ENTRY_SIZE = 8,
    parameter int CMT_ID_W   = 6,
    parameter int GRP_W      = 5,
    parameter int MISSU_N    = 4,
    parameter int STQ_N      = 16,
    parameter int PAYLOAD_W  = 96
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_haz_valid,
    input  logic [CMT_ID_W-1:0]  i_haz_cmt_id,
    input  logic [GRP_W-1:0]     i_haz_grp_id,
    input  logic [1:0]           i_haz_typ,
    input  logic [3:0]           i_haz_idx,
    input  logic [PAYLOAD_W-1:0] i_haz_payload,
    input  logic [MISSU_N-1:0]   i_missu_resolve_oh,
    input  logic                 i_missu_is_full,
    input  logic [STQ_N-1:0]     i_stq_resolve_oh,
    input  logic                 i_flush_all,
    input  logic                 i_br_flush_valid,
    input  logic [CMT_ID_W-1:0]  i_br_cmt_id,
    input  logic [GRP_W-1:0]     i_br_grp_id,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic                 o_req_valid,
    input  logic                 i_req_ready,
    output logic [CMT_ID_W-1:0]  o_req_cmt_id,
    output logic [GRP_W-1:0]     o_req_grp_id,
    output logic [1:0]           o_req_haz_typ,
    output logic [PAYLOAD_W-1:0] o_req_payload
`ifdef LSU_REPLAY_PERF_CNT_EN
    ,
    output logic [31:0]          o_perf_replay_cnt,
    output logic [31:0]          o_perf_full_cyc
`endif
);

    localparam int IDX_N = 16;  // range of the 4-bit wake index
    localparam int ENT_W = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1;
    localparam int CNT_W = $clog2(ENTRY_SIZE + 1);

    typedef enum logic [1:0] {E_FREE, E_WAIT, E_READY, E_SEL} ent_state_e;

    typedef struct packed {
        logic [CMT_ID_W-1:0]  cmt_id;
        logic [GRP_W-1:0]     grp_id;
        logic [1:0]           typ;
        logic [3:0]           idx;
        logic [PAYLOAD_W-1:0] payload;
    } ent_t;

    // a older than b: lower bits compare, inverted when the wrap bits differ;
    // same cmt_id falls back to grp_id where the lower one-hot bit is older.
    function automatic logic is_older(input logic [CMT_ID_W-1:0] a_cmt, input logic [GRP_W-1:0] a_grp,
                                      input logic [CMT_ID_W-1:0] b_cmt, input logic [GRP_W-1:0] b_grp);
        logic lower;
        lower = a_cmt[CMT_ID_W-2:0] < b_cmt[CMT_ID_W-2:0];
        if (a_cmt == b_cmt)                          is_older = a_grp < b_grp;
        else if (a_cmt[CMT_ID_W-1] == b_cmt[CMT_ID_W-1]) is_older = lower;
        else                                         is_older = ~lower;
    endfunction

    function automatic logic wake_hit(input logic [1:0] typ, input logic [3:0] idx, input logic missu_full,
                                      input logic [IDX_N-1:0] missu_res, input logic [IDX_N-1:0] stq_res);
        case (typ)
            2'd0:    wake_hit = 1'b1;
            2'd1:    wake_hit = ~missu_full;
            2'd2:    wake_hit = missu_res[idx];
            default: wake_hit = stq_res[idx];
        endcase
    endfunction

    ent_state_e           state_q [ENTRY_SIZE];
    ent_state_e           state_d [ENTRY_SIZE];
    ent_t                 ent_q   [ENTRY_SIZE];
    ent_t                 ent_d   [ENTRY_SIZE];

    logic                 out_valid_q, out_valid_d;
    logic [ENT_W-1:0]     out_idx_q, out_idx_d;
    logic [CMT_ID_W-1:0]  out_cmt_q, out_cmt_d;
    logic [GRP_W-1:0]     out_grp_q, out_grp_d;
    logic [1:0]           out_typ_q, out_typ_d;
    logic [PAYLOAD_W-1:0] out_pl_q, out_pl_d;
    logic                 full_q, full_d;
    logic                 afull_q, afull_d;

    logic [IDX_N-1:0]      missu_res_ext, stq_res_ext;
    logic [ENTRY_SIZE-1:0] kill;
    logic                  out_kill, hs, load, alloc, rep_kill;
    logic                  sel_found, alloc_found;
    logic [ENT_W-1:0]      sel_idx, alloc_idx;
    logic [CNT_W-1:0]      cnt_d;

    always_comb begin
        missu_res_ext = '0;
        stq_res_ext   = '0;
        for (int i = 0; i < MISSU_N; i++) missu_res_ext[i] = i_missu_resolve_oh[i];
        for (int i = 0; i < STQ_N; i++)   stq_res_ext[i]   = i_stq_resolve_oh[i];
    end

    always_comb begin
        kill = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            kill[i] = (state_q[i] != E_FREE) &&
                      (i_flush_all || (i_br_flush_valid &&
                       is_older(i_br_cmt_id, i_br_grp_id, ent_q[i].cmt_id, ent_q[i].grp_id)));
        end
        out_kill = out_valid_q && (i_flush_all || (i_br_flush_valid &&
                   is_older(i_br_cmt_id, i_br_grp_id, out_cmt_q, out_grp_q)));
        // a killed held request never completes a handshake
        hs = out_valid_q && i_req_ready && !out_kill;

        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (state_q[i] == E_READY && !kill[i] &&
                (!sel_found || is_older(ent_q[i].cmt_id, ent_q[i].grp_id,
                                        ent_q[sel_idx].cmt_id, ent_q[sel_idx].grp_id))) begin
                sel_found = 1'b1;
                sel_idx   = ENT_W'(i);
            end
        end
        // only refill an idle stage or one draining this cycle, so a held
        // request is never displaced by an older latecomer
        load = sel_found && (!out_valid_q || hs) && !out_kill;

        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (!alloc_found && state_q[i] == E_FREE) begin
                alloc_found = 1'b1;
                alloc_idx   = ENT_W'(i);
            end
        end
        rep_kill = i_flush_all || (i_br_flush_valid &&
                   is_older(i_br_cmt_id, i_br_grp_id, i_haz_cmt_id, i_haz_grp_id));
        alloc    = i_haz_valid && !full_q && alloc_found && !rep_kill;

        for (int i = 0; i < ENTRY_SIZE; i++) begin
            state_d[i] = state_q[i];
            ent_d[i]   = ent_q[i];
            case (state_q[i])
                E_WAIT:  if (wake_hit(ent_q[i].typ, ent_q[i].idx, i_missu_is_full, missu_res_ext, stq_res_ext))
                             state_d[i] = E_READY;
                E_READY: if (load && sel_idx == ENT_W'(i)) state_d[i] = E_SEL;
                E_SEL:   if (hs && out_idx_q == ENT_W'(i)) state_d[i] = E_FREE;
                default: ;
            endcase
            if (kill[i]) state_d[i] = E_FREE;
        end

        // wake condition checked on the report itself so a same-cycle resolve is not lost
        if (alloc) begin
            state_d[alloc_idx] = wake_hit(i_haz_typ, i_haz_idx, i_missu_is_full, missu_res_ext, stq_res_ext)
                                 ? E_READY : E_WAIT;
            ent_d[alloc_idx].cmt_id  = i_haz_cmt_id;
            ent_d[alloc_idx].grp_id  = i_haz_grp_id;
            ent_d[alloc_idx].typ     = i_haz_typ;
            ent_d[alloc_idx].idx     = i_haz_idx;
            ent_d[alloc_idx].payload = i_haz_payload;
        end

        cnt_d = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (state_d[i] != E_FREE) cnt_d = cnt_d + CNT_W'(1);
        end
        full_d  = (cnt_d == CNT_W'(ENTRY_SIZE));
        afull_d = (cnt_d >= CNT_W'(ENTRY_SIZE - 1));

        out_valid_d = out_valid_q && !hs && !out_kill;
        out_idx_d   = out_idx_q;
        out_cmt_d   = out_cmt_q;
        out_grp_d   = out_grp_q;
        out_typ_d   = out_typ_q;
        out_pl_d    = out_pl_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = sel_idx;
            out_cmt_d   = ent_q[sel_idx].cmt_id;
            out_grp_d   = ent_q[sel_idx].grp_id;
            out_typ_d   = ent_q[sel_idx].typ;
            out_pl_d    = ent_q[sel_idx].payload;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                state_q[i] <= E_FREE;
                ent_q[i]   <= '0;
            end
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_cmt_q   <= '0;
            out_grp_q   <= '0;
            out_typ_q   <= '0;
            out_pl_q    <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                state_q[i] <= state_d[i];
                ent_q[i]   <= ent_d[i];
            end
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_cmt_q   <= out_cmt_d;
            out_grp_q   <= out_grp_d;
            out_typ_q   <= out_typ_d;
            out_pl_q    <= out_pl_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
        end
    end

    assign o_full        = full_q;
    assign o_almost_full = afull_q;
    assign o_req_valid   = out_valid_q;
    assign o_req_cmt_id  = out_cmt_q;
    assign o_req_grp_id  = out_grp_q;
    assign o_req_haz_typ = out_typ_q;
    assign o_req_payload = out_pl_q;

`ifdef LSU_REPLAY_PERF_CNT_EN
    logic [31:0] perf_replay_q, perf_replay_d;
    logic [31:0] perf_full_q, perf_full_d;

    always_comb begin
        perf_replay_d = perf_replay_q;
        perf_full_d   = perf_full_q;
        if (hs && !(&perf_replay_q)) perf_replay_d = perf_replay_q + 32'd1;
        if (full_q && !(&perf_full_q)) perf_full_d = perf_full_q + 32'd1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            perf_replay_q <= '0;
            perf_full_q   <= '0;
        end else begin
            perf_replay_q <= perf_replay_d;
            perf_full_q   <= perf_full_d;
        end
    end

    assign o_perf_replay_cnt = perf_replay_q;
    assign o_perf_full_cyc   = perf_full_q;
`endif

    // reporting into a full pool is an upstream protocol violation
    a_no_report_when_full: assert property (@(posedge i_clk) disable iff (i_reset) !(i_haz_valid && full_q));

endmodule

// File: tb/tb_scariv_lsu_replay_sender.sv
// Directed bench for scariv_lsu_replay_sender. Expected requests are queued
// as reports are driven and compared in order on each output handshake.
module tb_scariv_lsu_replay_sender;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_haz_valid;
    logic [5:0]  i_haz_cmt_id;
    logic [4:0]  i_haz_grp_id;
    logic [1:0]  i_haz_typ;
    logic [3:0]  i_haz_idx;
    logic [95:0] i_haz_payload;
    logic [3:0]  i_missu_resolve_oh;
    logic        i_missu_is_full;
    logic [15:0] i_stq_resolve_oh;
    logic        i_flush_all;
    logic        i_br_flush_valid;
    logic [5:0]  i_br_cmt_id;
    logic [4:0]  i_br_grp_id;
    logic        o_full, o_almost_full, o_req_valid, i_req_ready;
    logic [5:0]  o_req_cmt_id;
    logic [4:0]  o_req_grp_id;
    logic [1:0]  o_req_haz_typ;
    logic [95:0] o_req_payload;
`ifdef LSU_REPLAY_PERF_CNT_EN
    logic [31:0] o_perf_replay_cnt, o_perf_full_cyc;
`endif

    scariv_lsu_replay_sender dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_haz_valid(i_haz_valid), .i_haz_cmt_id(i_haz_cmt_id), .i_haz_grp_id(i_haz_grp_id),
        .i_haz_typ(i_haz_typ), .i_haz_idx(i_haz_idx), .i_haz_payload(i_haz_payload),
        .i_missu_resolve_oh(i_missu_resolve_oh), .i_missu_is_full(i_missu_is_full),
        .i_stq_resolve_oh(i_stq_resolve_oh), .i_flush_all(i_flush_all),
        .i_br_flush_valid(i_br_flush_valid), .i_br_cmt_id(i_br_cmt_id), .i_br_grp_id(i_br_grp_id),
        .o_full(o_full), .o_almost_full(o_almost_full), .o_req_valid(o_req_valid),
        .i_req_ready(i_req_ready), .o_req_cmt_id(o_req_cmt_id), .o_req_grp_id(o_req_grp_id),
        .o_req_haz_typ(o_req_haz_typ), .o_req_payload(o_req_payload)
`ifdef LSU_REPLAY_PERF_CNT_EN
        , .o_perf_replay_cnt(o_perf_replay_cnt), .o_perf_full_cyc(o_perf_full_cyc)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [5:0]  cmt;
        logic [4:0]  grp;
        logic [95:0] pl;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [95:0] pl(input logic [5:0] cmt);
        pl = {32'hA5A5_5A00 ^ 32'(cmt), 32'hDEAD_BEEF + 32'(cmt), 32'(cmt) * 32'd7};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [5:0] cmt, input logic [4:0] grp);
        exp_t e;
        e.cmt = cmt; e.grp = grp; e.pl = pl(cmt);
        exp_q.push_back(e);
    endtask

    // one clock: score a handshake about to happen at the coming edge, then advance
    task automatic cyc();
        exp_t e;
        if (o_req_valid && i_req_ready && !i_flush_all && !i_br_flush_valid) begin
            if (exp_q.size() == 0) chk("unexpected_req", {122'd0, o_req_cmt_id}, 128'h3F_DEAD);
            else begin
                e = exp_q.pop_front();
                chk("req_cmt", 128'(o_req_cmt_id), 128'(e.cmt));
                chk("req_grp", 128'(o_req_grp_id), 128'(e.grp));
                chk("req_payload", 128'(o_req_payload), 128'(e.pl));
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic report(input logic [5:0] cmt, input logic [4:0] grp, input logic [1:0] typ, input logic [3:0] idx);
        i_haz_valid = 1'b1; i_haz_cmt_id = cmt; i_haz_grp_id = grp;
        i_haz_typ = typ; i_haz_idx = idx; i_haz_payload = pl(cmt);
        cyc();
        i_haz_valid = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_haz_valid = 0; i_haz_cmt_id = 0; i_haz_grp_id = 0; i_haz_typ = 0;
        i_haz_idx = 0; i_haz_payload = 0; i_missu_resolve_oh = 0; i_missu_is_full = 0;
        i_stq_resolve_oh = 0; i_flush_all = 0; i_br_flush_valid = 0; i_br_cmt_id = 0;
        i_br_grp_id = 0; i_req_ready = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid", 128'(o_req_valid), 128'd0);
        chk("rst_full", 128'(o_full), 128'd0);
        chk("rst_afull", 128'(o_almost_full), 128'd0);
        chk("rst_cmt", 128'(o_req_cmt_id), 128'd0);
        chk("rst_typ", 128'(o_req_haz_typ), 128'd0);
        chk("rst_payload", 128'(o_req_payload), 128'd0);
        i_reset = 1'b0;
        cyc();

        // 1: typ0 latency N+2
        i_req_ready = 1'b1;
        push(6'd5, 5'b00001);
        report(6'd5, 5'b00001, 2'd0, 4'd0);
        chk("t1_n1_valid", 128'(o_req_valid), 128'd0);
        cyc();
        chk("t1_n2_valid", 128'(o_req_valid), 128'd1);
        cyc();
        chk("t1_after_valid", 128'(o_req_valid), 128'd0);

        // 2: typ2 idx3, wrong resolve bit ignored, right one at N+4 -> N+6
        push(6'd6, 5'b00001);
        report(6'd6, 5'b00001, 2'd2, 4'd3);
        for (int k = 1; k <= 5; k++) begin
            i_missu_resolve_oh = (k == 2) ? 4'b0100 : (k == 4) ? 4'b1000 : 4'b0000;
            chk("t2_wait_valid", 128'(o_req_valid), 128'd0);
            cyc();
        end
        i_missu_resolve_oh = 4'b0000;
        chk("t2_n6_valid", 128'(o_req_valid), 128'd1);
        cyc();

        // 3: wrapped age order, back to back
        push(6'h3E, 5'b00001);
        push(6'h02, 5'b00001);
        report(6'h02, 5'b00001, 2'd3, 4'd5);
        report(6'h3E, 5'b00001, 2'd3, 4'd5);
        i_stq_resolve_oh = 16'h0020;
        cyc();
        i_stq_resolve_oh = 16'h0000;
        cyc();
        chk("t3_first", 128'(o_req_cmt_id), 128'h3E);
        cyc();
        chk("t3_second_valid", 128'(o_req_valid), 128'd1);
        chk("t3_second", 128'(o_req_cmt_id), 128'h02);
        cyc();
        chk("t3_idle", 128'(o_req_valid), 128'd0);

        // 4: hold with ready=0 while an older entry wakes
        i_req_ready = 1'b0;
        push(6'h21, 5'b00001);
        push(6'h20, 5'b00001);
        report(6'h20, 5'b00001, 2'd2, 4'd1);
        report(6'h21, 5'b00001, 2'd0, 4'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            i_missu_resolve_oh = (k == 0) ? 4'b0010 : 4'b0000;
            chk("t4_hold_valid", 128'(o_req_valid), 128'd1);
            chk("t4_hold_cmt", 128'(o_req_cmt_id), 128'h21);
            chk("t4_hold_payload", 128'(o_req_payload), 128'(pl(6'h21)));
            cyc();
        end
        i_missu_resolve_oh = 4'b0000;
        i_req_ready = 1'b1;
        cyc();
        chk("t4_older_next", 128'(o_req_cmt_id), 128'h20);
        cyc();
        chk("t4_idle", 128'(o_req_valid), 128'd0);

        // 5: fill, branch flush kills strictly younger
        for (int k = 0; k < 8; k++) begin
            report(6'h0D + 6'(k), 5'b00001, 2'd2, 4'd0);
            chk("t5_afull", 128'(o_almost_full), 128'(k >= 6));
            chk("t5_full", 128'(o_full), 128'(k == 7));
        end
        i_br_flush_valid = 1'b1; i_br_cmt_id = 6'h10; i_br_grp_id = 5'b00001;
        cyc();
        i_br_flush_valid = 1'b0;
        chk("t5_flush_full", 128'(o_full), 128'd0);
        chk("t5_flush_afull", 128'(o_almost_full), 128'd0);
        for (int k = 0; k < 4; k++) push(6'h0D + 6'(k), 5'b00001);
        i_missu_resolve_oh = 4'b0001;
        cyc();
        i_missu_resolve_oh = 4'b0000;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc();
        chk("t5_drain_left", 128'(exp_q.size()), 128'd0);
        cyc();
        chk("t5_no_killed_issue", 128'(o_req_valid), 128'd0);

        // flush_all kills the held request and a same-cycle report
        i_req_ready = 1'b0;
        report(6'h08, 5'b00001, 2'd0, 4'd0);
        cyc();
        chk("fa_held", 128'(o_req_valid), 128'd1);
        i_flush_all = 1'b1; i_req_ready = 1'b1;
        report(6'h09, 5'b00001, 2'd0, 4'd0);
        i_flush_all = 1'b0;
        chk("fa_valid", 128'(o_req_valid), 128'd0);
        cyc();
        cyc();
        chk("fa_dropped", 128'(o_req_valid), 128'd0);

`ifdef LSU_REPLAY_PERF_CNT_EN
        chk("perf_replay", 128'(o_perf_replay_cnt), 128'd10);
        chk("perf_full", 128'(o_perf_full_cyc), 128'd1);
`endif

        // 6: async reset while holding
        i_req_ready = 1'b0;
        report(6'h07, 5'b00010, 2'd0, 4'd0);
        cyc();
        chk("t6_held", 128'(o_req_valid), 128'd1);
        cyc();
        #2 i_reset = 1'b1;
        #1;
        chk("t6_rst_valid", 128'(o_req_valid), 128'd0);
        chk("t6_rst_cmt", 128'(o_req_cmt_id), 128'd0);
        chk("t6_rst_full", 128'(o_full), 128'd0);
`ifdef LSU_REPLAY_PERF_CNT_EN
        chk("t6_perf_replay", 128'(o_perf_replay_cnt), 128'd0);
        chk("t6_perf_full", 128'(o_perf_full_cyc), 128'd0);
`endif
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        cyc();
        cyc();
        chk("t6_post_valid", 128'(o_req_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
